cnt0_counter_core: RTL

CNT0_COUNTER_CORE -- requirements
Module: cnt0_counter_core

---
 rtl/cnt0_counter_core.sv | 63 ++++++
 1 files changed

// File: rtl/cnt0_counter_core.sv
// cnt0_counter_core: prescaled counter core with periodic down-count (CNT) and saturating up/down (FSM) modes.
module cnt0_counter_core #(
  parameter int BIT_WIDTH = 14
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_cnt_reset_n,
  input  logic                 i_mode,
  input  logic                 i_up,
  input  logic                 i_keep,
  input  logic [1:0]           i_div_sel,
  input  logic [BIT_WIDTH-1:0] i_data,
  output logic [BIT_WIDTH-1:0] o_counter,
  output logic                 o_reload
);
  typedef enum logic [1:0] {LOAD, RUN, HOLD} state_t;
  localparam logic [BIT_WIDTH-1:0] ONE = 1;
  state_t                 r_state, w_state_nxt;
  logic [BIT_WIDTH-1:0]   r_counter, w_counter_nxt;
  logic [4:0]             r_presc, w_presc_nxt, w_lim;
  logic                   r_reload, w_reload_nxt, w_tick, w_hold;
  assign o_counter = r_counter;
  assign o_reload  = r_reload;
  assign w_lim  = i_div_sel == 2'd0 ? 5'd0 : i_div_sel == 2'd1 ? 5'd3 : i_div_sel == 2'd2 ? 5'd11 : 5'd23;
  assign w_tick = r_presc >= w_lim;
  assign w_hold = i_mode & i_keep;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_state   <= LOAD;
      r_counter <= '0;
      r_presc   <= '0;
      r_reload  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_counter <= w_counter_nxt;
      r_presc   <= w_presc_nxt;
      r_reload  <= w_reload_nxt;
    end
  // A reload request overrides every other condition, in any state.
  always_comb begin
    w_state_nxt   = r_state;
    w_counter_nxt = r_counter;
    w_presc_nxt   = r_presc;
    w_reload_nxt  = 1'b0;
    if (!i_cnt_reset_n || r_state == LOAD) begin
      w_counter_nxt = i_data;
      w_presc_nxt   = '0;
      w_state_nxt   = i_cnt_reset_n ? RUN : LOAD;
    end else if (r_state == RUN) begin
      if (w_hold) w_state_nxt = HOLD;
      else begin
        w_presc_nxt = w_tick ? 5'd0 : r_presc + 5'd1;
        if (w_tick && !i_mode) begin
          w_counter_nxt = r_counter == '0 ? i_data : r_counter - ONE;
          w_reload_nxt  = r_counter == '0;
        end else if (w_tick)
          w_counter_nxt = i_up ? (&r_counter ? r_counter : r_counter + ONE)
                               : (r_counter == '0 ? r_counter : r_counter - ONE);
      end
    end else
      w_state_nxt = w_hold ? HOLD : RUN;
  end
endmodule
